aes_core_scheduler: RTL
=======================

Name: aes_core_scheduler

Overview:
- Shares one iterative AES-128 encryption core between NUM_REQ requesters.
- Each requester presents a plaintext/key pair on a valid/ready handshake. The block grants one requester at a time, round-robin.
- It loads the core, pulses start, waits for done with a timeout, and returns the ciphertext tagged with the requester ID on a valid/ready response port.
- Sits between the request fabric and the AES core instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID; must satisfy 2**ID_W >= NUM_REQ
TIMEOUT, 64, max WAIT cycles for core_done before error (8..255)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept, at most one bit set
req_plaintext  input  NUM_REQ*128  slice i = [128*i +: 128]
req_key  input  NUM_REQ*128  slice i = [128*i +: 128]
core_start  output  1  one-cycle start pulse to AES core
core_plaintext  output  128  plaintext to core, stable from ISSUE through end of WAIT
core_key  output  128  key to core, stable from ISSUE through end of WAIT
core_done  input  1  core completion pulse
core_ciphertext  input  128  valid in the core_done cycle
resp_valid  output  1  response valid
resp_ready  input  1  response accept
resp_id  output  ID_W  index of the served requester
resp_data  output  128  ciphertext, or 0 on error
resp_err  output  1  1 = timeout
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. It has priority over everything, including mid-operation.
- Reset values:
  - state IDLE, rr_ptr = 0, timer = 0.
  - req_ready = 0, core_start = 0, resp_valid = 0, resp_err = 0, busy = 0.
  - resp_id = 0, resp_data = 0, core_plaintext = 0, core_key = 0.
- Reset mid-operation: any captured request is dropped with no response. The core is not reset by this block.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE, arbitration:
  - Grant goes to the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[grant] is combinational = (state==IDLE) && req_valid[grant]. All other bits are 0.
  - On handshake: register plaintext, key and grant ID, then go to ISSUE.
  - req_ready is 0 in every state other than IDLE.
- ISSUE: lasts exactly 1 cycle.
  - core_start = 1; core_plaintext/core_key driven from the captured registers.
  - timer cleared to 0; go to WAIT.
- WAIT:
  - timer increments each cycle; core_done is sampled.
  - On core_done=1: latch core_ciphertext into resp_data, resp_err = 0, go to RESP.
  - If timer reaches TIMEOUT-1 without core_done: resp_data = 0, resp_err = 1, go to RESP.
  - If core_done and timeout occur in the same cycle, done wins (resp_err = 0).
  - core_done outside WAIT is ignored.
- RESP:
  - resp_valid = 1. resp_id, resp_data and resp_err are held stable until resp_ready=1.
  - On handshake: rr_ptr = (grant+1) mod NUM_REQ, go to IDLE. resp_valid drops on the next cycle.
  - Requester whose slot is granted while resp_valid is held low cannot be accepted; there is no request/response overlap.
- Throughput and latency:
  - Minimum spacing between accepts = core latency + 3 cycles.
  - Accept-to-resp_valid latency = 1 (ISSUE) + core cycles to done + 1.
- req_valid deassertion before handshake is legal. A request withdrawn before handshake is never served.
- Wrap-around: rr_ptr rolls from NUM_REQ-1 to 0. The timer is sized to hold TIMEOUT and never wraps.

Test Plan:
- Single request, FIPS-197 vector: requester 2 sends pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f. The core model returns 69c4e0d86a7b0430d8cdb78070b4c55a after 20 cycles. Required: exactly one core_start pulse, resp_id=2, resp_err=0, resp_data equal to the model output.
- Fairness: all 4 req_valid held high for 8 transactions. Required: grant order 0,1,2,3,0,1,2,3; req_ready one-hot; never two grants without an intervening RESP handshake.
- Timeout: core model never asserts done, TIMEOUT=64. Required: resp_valid rises 64 cycles after ISSUE, resp_err=1, resp_data=0; next request is served normally.
- Done/timeout tie: core_done asserted in the same cycle the timer reaches TIMEOUT-1. Required: resp_err=0 and resp_data = core_ciphertext.
- Response backpressure: resp_ready held 0 for 10 cycles. Required: resp_valid/resp_id/resp_data stable throughout, req_ready stays 0 for all requesters, busy=1.
- Mid-operation reset: rst asserted for 1 cycle during WAIT. Required: next cycle shows all outputs at reset values; a subsequent core_done is ignored; no response is emitted; rr_ptr = 0.

Source files
------------

// File: rtl/aes_core_scheduler_if.sv
// aes_core_scheduler_if
//   Bundles the request fabric, AES core and response signals of the
//   shared-core scheduler.
//   master : the scheduler side (takes requests, drives the core, returns responses)
//   slave  : the environment side (requesters, AES core, response consumer)
//   Signals:
//     req_valid/req_ready/req_plaintext/req_key : per-requester request handshake
//     core_start/core_plaintext/core_key        : command to the AES core
//     core_done/core_ciphertext                 : completion from the AES core
//     resp_valid/resp_ready/resp_id/resp_data/resp_err : response handshake
//     busy                                      : scheduler not idle
interface aes_core_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*128-1:0] req_plaintext;
  logic [NUM_REQ*128-1:0] req_key;
  logic                   core_start;
  logic [127:0]           core_plaintext;
  logic [127:0]           core_key;
  logic                   core_done;
  logic [127:0]           core_ciphertext;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [ID_W-1:0]        resp_id;
  logic [127:0]           resp_data;
  logic                   resp_err;
  logic                   busy;

  modport master (
    input  req_valid, req_plaintext, req_key, core_done, core_ciphertext, resp_ready,
    output req_ready, core_start, core_plaintext, core_key,
           resp_valid, resp_id, resp_data, resp_err, busy
  );

  modport slave (
    output req_valid, req_plaintext, req_key, core_done, core_ciphertext, resp_ready,
    input  req_ready, core_start, core_plaintext, core_key,
           resp_valid, resp_id, resp_data, resp_err, busy
  );
endinterface

// File: rtl/aes_core_scheduler.sv
// aes_core_scheduler
//   Shares one iterative AES-128 core between NUM_REQ requesters. Requests
//   are granted round-robin, one at a time; the core is started with a
//   one-cycle pulse, its completion is awaited with a timeout, and the
//   ciphertext (or 0 with an error flag) is returned tagged with the
//   requester ID.
//   Ports:
//     clk : clock, rising edge
//     rst : synchronous active-high reset (drops any request in flight)
//     bus : aes_core_scheduler_if.master (request, core and response signals)
module aes_core_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  aes_core_scheduler_if.master bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [ID_W-1:0] LAST_ID    = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_grant;
  logic [TW-1:0]   r_timer;
  logic [127:0]    r_plaintext;
  logic [127:0]    r_key;
  logic            r_core_start;
  logic            r_resp_valid;
  logic [ID_W-1:0] r_resp_id;
  logic [127:0]    r_resp_data;
  logic            r_resp_err;
  logic            r_busy;

  logic               w_found;
  logic [ID_W-1:0]    w_grant;
  logic [NUM_REQ-1:0] w_req_ready;
  logic               w_accept;

  // Round-robin search starting at r_rr_ptr. The loop runs from the
  // farthest offset down so the nearest valid requester is written last.
  always_comb begin
    int w_idx;
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (bus.req_valid[ID_W'(w_idx)]) begin
        w_found = 1'b1;
        w_grant = ID_W'(w_idx);
      end
    end
  end

  // The granted requester is valid by construction, so ready doubles as
  // the handshake indication.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign w_req_ready[gi] = (r_state == ST_IDLE) && w_found && (w_grant == ID_W'(gi));
    end
  endgenerate

  assign w_accept = (r_state == ST_IDLE) && w_found;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_grant      <= '0;
      r_timer      <= '0;
      r_plaintext  <= '0;
      r_key        <= '0;
      r_core_start <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_plaintext  <= bus.req_plaintext[128*w_grant +: 128];
            r_key        <= bus.req_key[128*w_grant +: 128];
            r_grant      <= w_grant;
            r_core_start <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_core_start <= 1'b0;
          r_timer      <= '0;
          r_state      <= ST_WAIT;
        end
        ST_WAIT: begin
          // Done is tested first so a completion in the final allowed
          // cycle still returns good data. TIMEOUT WAIT cycles in total.
          if (bus.core_done) begin
            r_resp_data  <= bus.core_ciphertext;
            r_resp_err   <= 1'b0;
            r_resp_id    <= r_grant;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end else if (r_timer == TIMER_LAST) begin
            r_resp_data  <= '0;
            r_resp_err   <= 1'b1;
            r_resp_id    <= r_grant;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_rr_ptr     <= (r_grant == LAST_ID) ? '0 : r_grant + 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready      = w_req_ready;
  assign bus.core_start     = r_core_start;
  assign bus.core_plaintext = r_plaintext;
  assign bus.core_key       = r_key;
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_id        = r_resp_id;
  assign bus.resp_data      = r_resp_data;
  assign bus.resp_err       = r_resp_err;
  assign bus.busy           = r_busy;

endmodule
